// File: rtl/rgmii_rx_ecp5.sv
// rgmii_rx_ecp5 -- RGMII receiver for Lattice ECP5.
// Captures the DDR RX_CTL/RXD pads, decodes (dv, er, byte) and strips the
// preamble/SFD. Payload bytes leave with sof/eof/error framing.
// Build options:
//   RGMII_RX_INBAND_STATUS_EN -- decode in-band link/speed/duplex from idle bytes;
//                                when undefined the status outputs are constant
//                                (link up, 1000M, full duplex) after reset.
//   SYNTHESIS                 -- instantiate the vendor IDDRX1F primitives; otherwise
//                                an equivalent behavioural capture model is used.
module rgmii_rx_ecp5 (
   input  logic       clk,
   input  logic       rst,
   input  logic       pad_rx_ctl,
   input  logic [3:0] pad_rx_dat,
   output logic       valid,
   output logic       error,
   output logic [7:0] data,
   output logic       sof,
   output logic       eof,
   output logic       link_up,
   output logic [1:0] speed,
   output logic       full_duplex
);

   localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0] SFD_BYTE      = 8'hD5;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PRE  = 2'd1,
      S_DATA = 2'd2,
      S_DROP = 2'd3
   } state_t;

   // bit 4 = RX_CTL, bits 3:0 = RXD
   logic [4:0] w_pad;
   logic [4:0] w_rise_p0;
   logic [4:0] w_fall_p0;

   assign w_pad = {pad_rx_ctl, pad_rx_dat};

   // ---- stage p0: DDR capture (rising/falling pair aligned to posedge) ----
`ifdef SYNTHESIS
   for (genvar g = 0; g < 5; g++) begin : g_iddr
      IDDRX1F u_iddr (
         .D    (w_pad[g]),
         .SCLK (clk),
         .RST  (rst),
         .Q0   (w_rise_p0[g]),
         .Q1   (w_fall_p0[g])
      );
   end
`else
   logic [4:0] r_rise_cap;
   logic [4:0] r_fall_cap;
   logic [4:0] r_rise_p0;
   logic [4:0] r_fall_p0;

   // rising-edge sample of the pads
   always_ff @(posedge clk) begin
      if (rst) r_rise_cap <= '0;
      else     r_rise_cap <= w_pad;
   end

   // falling-edge sample of the pads (second half of the same byte)
   always_ff @(negedge clk) begin
      r_fall_cap <= w_pad;
   end

   // re-time both halves onto the rising edge as one pair
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rise_p0 <= '0;
         r_fall_p0 <= '0;
      end else begin
         r_rise_p0 <= r_rise_cap;
         r_fall_p0 <= r_fall_cap;
      end
   end

   assign w_rise_p0 = r_rise_p0;
   assign w_fall_p0 = r_fall_p0;
`endif

   logic       w_dv_p0;
   logic       w_er_p0;
   logic [7:0] w_byte_p0;

   assign w_dv_p0   = w_rise_p0[4];
   assign w_er_p0   = w_rise_p0[4] ^ w_fall_p0[4];
   assign w_byte_p0 = {w_fall_p0[3:0], w_rise_p0[3:0]};

   // ---- stage p1: decoded dv/er/byte ----
   logic       r_dv_p1;
   logic       r_er_p1;
   logic [7:0] r_byte_p1;

   // decode register; byte is cleared too so in-band status never sees stale data
   always_ff @(posedge clk) begin
      if (rst) begin
         r_dv_p1   <= 1'b0;
         r_er_p1   <= 1'b0;
         r_byte_p1 <= '0;
      end else begin
         r_dv_p1   <= w_dv_p0;
         r_er_p1   <= w_er_p0;
         r_byte_p1 <= w_byte_p0;
      end
   end

   state_t r_state;
   state_t w_state_nxt;
   logic   w_emit;
   logic   r_first;

   // frame state register
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // next state and emit decision; dv=0 with er=1 (extension/false carrier) freezes the FSM
   always_comb begin
      w_state_nxt = r_state;
      w_emit      = 1'b0;
      if (r_dv_p1 || !r_er_p1) begin
         case (r_state)
            S_IDLE: begin
               if (r_dv_p1) begin
                  if (r_byte_p1 == PREAMBLE_BYTE)  w_state_nxt = S_PRE;
                  else if (r_byte_p1 == SFD_BYTE)  w_state_nxt = S_DATA;
                  else                             w_state_nxt = S_DROP;
               end
            end
            S_PRE: begin
               if (!r_dv_p1)                       w_state_nxt = S_IDLE;
               else if (r_byte_p1 == SFD_BYTE)     w_state_nxt = S_DATA;
               else if (r_byte_p1 != PREAMBLE_BYTE) w_state_nxt = S_DROP;
            end
            S_DATA: begin
               if (!r_dv_p1) w_state_nxt = S_IDLE;
               else          w_emit      = 1'b1;
            end
            S_DROP: begin
               if (!r_dv_p1) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   // marks the first payload byte after the SFD
   always_ff @(posedge clk) begin
      if (rst)                                             r_first <= 1'b0;
      else if (r_state != S_DATA && w_state_nxt == S_DATA) r_first <= 1'b1;
      else if (w_emit)                                     r_first <= 1'b0;
   end

   // ---- stage p2: holding/output register; eof looks ahead at the next pair's dv ----
   logic       r_valid;
   logic       r_error;
   logic       r_sof;
   logic       r_eof;
   logic [7:0] r_data;

   // held byte is presented with its framing flags for exactly one cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_error <= 1'b0;
         r_sof   <= 1'b0;
         r_eof   <= 1'b0;
         r_data  <= '0;
      end else begin
         r_valid <= w_emit;
         r_error <= w_emit & r_er_p1;
         r_sof   <= w_emit & r_first;
         r_eof   <= w_emit & ~w_dv_p0;
         if (w_emit) r_data <= r_byte_p1;
      end
   end

   assign valid = r_valid;
   assign error = r_error;
   assign sof   = r_sof;
   assign eof   = r_eof;
   assign data  = r_data;

   logic       r_link_up;
   logic [1:0] r_speed;
   logic       r_full_duplex;

`ifdef RGMII_RX_INBAND_STATUS_EN
   logic w_status_upd;

   assign w_status_upd = !r_dv_p1 && !r_er_p1 && (r_byte_p1[3:0] == r_byte_p1[7:4]);

   // in-band status from idle bytes whose two nibbles agree
   always_ff @(posedge clk) begin
      if (rst) begin
         r_link_up     <= 1'b0;
         r_speed       <= 2'b00;
         r_full_duplex <= 1'b0;
      end else if (w_status_upd) begin
         r_link_up     <= r_byte_p1[0];
         r_speed       <= r_byte_p1[2:1];
         r_full_duplex <= r_byte_p1[3];
      end
   end
`else
   // fixed status: gigabit full duplex, link up once out of reset
   always_ff @(posedge clk) begin
      if (rst) begin
         r_link_up     <= 1'b0;
         r_speed       <= 2'b00;
         r_full_duplex <= 1'b0;
      end else begin
         r_link_up     <= 1'b1;
         r_speed       <= 2'b10;
         r_full_duplex <= 1'b1;
      end
   end
`endif

   assign link_up     = r_link_up;
   assign speed       = r_speed;
   assign full_duplex = r_full_duplex;

endmodule

// File: tb/tb_rgmii_rx_ecp5.sv
// tb_rgmii_rx_ecp5 -- directed and random frames against a frame-level reference model.
`timescale 1ns/1ps
module tb_rgmii_rx_ecp5;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       pad_rx_ctl = 1'b0;
   logic [3:0] pad_rx_dat = 4'h0;
   logic       valid, error, sof, eof, link_up, full_duplex;
   logic [7:0] data;
   logic [1:0] speed;

   rgmii_rx_ecp5 dut (
      .clk         (clk),
      .rst         (rst),
      .pad_rx_ctl  (pad_rx_ctl),
      .pad_rx_dat  (pad_rx_dat),
      .valid       (valid),
      .error       (error),
      .data        (data),
      .sof         (sof),
      .eof         (eof),
      .link_up     (link_up),
      .speed       (speed),
      .full_duplex (full_duplex)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_err = 0;

   // stimulus record, indexed by the cycle whose rising edge captured the byte
   logic       s_dv [int];
   logic       s_er [int];
   logic [7:0] s_b  [int];
   int         last_k = 0;
   int         seg_start = 0;

   logic [31:0] obs_q [$];
   logic [31:0] exp_q [$];

   function automatic logic [31:0] pack(input int c, input logic so, input logic eo,
                                        input logic er, input logic [7:0] d);
      logic [15:0] c16;
      c16 = c[15:0];
      return {c16, 5'd0, so, eo, er, d};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   // every emitted byte: {cycle, sof, eof, error, data}
   always @(negedge clk) begin
      if (valid === 1'b1) obs_q.push_back(pack(cyc, sof, eof, error, data));
   end

   // one byte time on the pads: rising half before posedge, falling half after it
   task automatic drive(input logic dv, input logic er, input logic [7:0] b, input logic r);
      int k;
      @(negedge clk); #1;
      k = cyc + 1;
      s_dv[k] = dv; s_er[k] = er; s_b[k] = b;
      last_k = k;
      rst = r;
      pad_rx_ctl = dv;
      pad_rx_dat = b[3:0];
      @(posedge clk); #1;
      pad_rx_ctl = dv ^ er;
      pad_rx_dat = b[7:4];
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 1'b0, 8'h00, 1'b0);
   endtask

   task automatic preamble_sfd();
      repeat (7) drive(1'b1, 1'b0, 8'h55, 1'b0);
      drive(1'b1, 1'b0, 8'hD5, 1'b0);
   endtask

   task automatic seg_begin();
      obs_q.delete();
      seg_start = last_k + 1;
   endtask

   // reference: split the recorded stream into dv runs; a run whose leading
   // 0x55* is followed by 0xD5 delivers the remaining bytes 3 cycles later
   task automatic model_seg(input int s, input int e);
      int i, r, p;
      exp_q.delete();
      i = s;
      while (i <= e) begin
         if (!s_dv[i]) begin
            i++;
         end else begin
            r = i;
            while (r + 1 <= e && s_dv[r+1]) r++;
            p = i;
            while (p <= r && s_b[p] == 8'h55) p++;
            if (p <= r && s_b[p] == 8'hD5) begin
               for (int q = p + 1; q <= r; q++)
                  exp_q.push_back(pack(q + 3, q == p + 1, q == r, s_er[q], s_b[q]));
            end
            i = r + 1;
         end
      end
   endtask

   task automatic seg_compare(input string tag);
      int n;
      idle(6);
      model_seg(seg_start, last_k);
      check({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) check(tag, obs_q[i], exp_q[i]);
      obs_q.delete();
   endtask

   task automatic rand_frame();
      int ext, gap, plen, pos, dlen;
      logic [7:0] b;
      logic e;
      ext = $urandom_range(0, 2);
      repeat (ext) drive(1'b0, 1'b1, 8'($urandom), 1'b0);
      gap = $urandom_range(1, 3);
      repeat (gap) drive(1'b0, 1'b0, 8'($urandom), 1'b0);
      plen = $urandom_range(0, 7);
      pos  = ($urandom_range(0, 5) == 0) ? $urandom_range(0, plen) : -1;
      for (int i = 0; i <= plen; i++) begin
         b = (i == plen) ? 8'hD5 : 8'h55;
         if (i == pos) b = 8'($urandom);
         e = ($urandom_range(0, 7) == 0);
         drive(1'b1, e, b, 1'b0);
      end
      dlen = $urandom_range(1, 12);
      for (int i = 0; i < dlen; i++) begin
         e = ($urandom_range(0, 7) == 0);
         drive(1'b1, e, 8'($urandom), 1'b0);
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int p0;
      logic [7:0] pl [0:5];
      pl[0] = 8'h21; pl[1] = 8'h32; pl[2] = 8'h43;
      pl[3] = 8'h64; pl[4] = 8'h76; pl[5] = 8'h87;

      // reset state
      repeat (4) drive(1'b0, 1'b0, 8'h00, 1'b1);
      check("rst_valid",  32'(valid), 32'd0);
      check("rst_error",  32'(error), 32'd0);
      check("rst_sof",    32'(sof),   32'd0);
      check("rst_eof",    32'(eof),   32'd0);
      check("rst_data",   32'(data),  32'd0);
      check("rst_link",   32'(link_up), 32'd0);
      check("rst_speed",  32'(speed), 32'd0);
      check("rst_duplex", 32'(full_duplex), 32'd0);
      idle(4);

      // in-band status
`ifdef RGMII_RX_INBAND_STATUS_EN
      repeat (4) drive(1'b0, 1'b0, 8'hDD, 1'b0);
      check("status_dd", 32'({link_up, speed, full_duplex}), 32'hD);
      repeat (4) drive(1'b0, 1'b0, 8'hD3, 1'b0);
      check("status_d3", 32'({link_up, speed, full_duplex}), 32'hD);
      repeat (4) drive(1'b0, 1'b0, 8'h00, 1'b0);
      check("status_00", 32'({link_up, speed, full_duplex}), 32'h0);
`else
      repeat (4) drive(1'b0, 1'b0, 8'hDD, 1'b0);
      check("status_const", 32'({link_up, speed, full_duplex}), 32'hD);
`endif

      // full preamble, four payload bytes
      seg_begin();
      idle(3); preamble_sfd();
      drive(1'b1, 1'b0, 8'h01, 1'b0);
      p0 = last_k;
      drive(1'b1, 1'b0, 8'h02, 1'b0);
      drive(1'b1, 1'b0, 8'h03, 1'b0);
      drive(1'b1, 1'b0, 8'h04, 1'b0);
      idle(6);
      check("basic_n", 32'(obs_q.size()), 32'd4);
      if (obs_q.size() > 0) check("basic_first", obs_q[0], pack(p0 + 3, 1'b1, 1'b0, 1'b0, 8'h01));
      if (obs_q.size() > 3) check("basic_last",  obs_q[3], pack(p0 + 6, 1'b0, 1'b1, 1'b0, 8'h04));
      seg_compare("basic");

      // zero-length preamble, one-byte frame
      seg_begin();
      idle(3);
      drive(1'b1, 1'b0, 8'hD5, 1'b0);
      drive(1'b1, 1'b0, 8'hAA, 1'b0);
      p0 = last_k;
      idle(6);
      check("onebyte_n", 32'(obs_q.size()), 32'd1);
      if (obs_q.size() > 0) check("onebyte", obs_q[0], pack(p0 + 3, 1'b1, 1'b1, 1'b0, 8'hAA));
      seg_compare("onebyte");

      // corrupted preamble dropped, next frame accepted
      seg_begin();
      idle(3);
      drive(1'b1, 1'b0, 8'h55, 1'b0);
      drive(1'b1, 1'b0, 8'h55, 1'b0);
      drive(1'b1, 1'b0, 8'h12, 1'b0);
      drive(1'b1, 1'b0, 8'hD5, 1'b0);
      drive(1'b1, 1'b0, 8'h33, 1'b0);
      idle(3); preamble_sfd();
      drive(1'b1, 1'b0, 8'hA1, 1'b0);
      drive(1'b1, 1'b0, 8'hB2, 1'b0);
      drive(1'b1, 1'b0, 8'hC3, 1'b0);
      seg_compare("badpre");

      // error flag on one byte, then extension and false carrier
      seg_begin();
      idle(3); preamble_sfd();
      drive(1'b1, 1'b0, 8'h10, 1'b0);
      drive(1'b1, 1'b1, 8'h20, 1'b0);
      p0 = last_k;
      drive(1'b1, 1'b0, 8'h30, 1'b0);
      repeat (2) drive(1'b0, 1'b1, 8'h0F, 1'b0);
      idle(2);
      repeat (3) drive(1'b0, 1'b1, 8'h0F, 1'b0);
      idle(6);
      if (obs_q.size() > 1) check("err_byte", obs_q[1], pack(p0 + 3, 1'b0, 1'b0, 1'b1, 8'h20));
      else check("err_byte_n", 32'(obs_q.size()), 32'd3);
      seg_compare("errflag");

      // reset after two payload bytes have been delivered
      seg_begin();
      idle(3); preamble_sfd();
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 1'b0, pl[i], (i == 5) ? 1'b1 : 1'b0);
         if (i == 0) p0 = last_k;
      end
      idle(8);
      check("rstmid_n", 32'(obs_q.size()), 32'd2);
      if (obs_q.size() > 0) check("rstmid_b0", obs_q[0], pack(p0 + 3, 1'b1, 1'b0, 1'b0, pl[0]));
      if (obs_q.size() > 1) check("rstmid_b1", obs_q[1], pack(p0 + 4, 1'b0, 1'b0, 1'b0, pl[1]));

      // reset early in the payload: rest of the frame must be dropped
      seg_begin();
      idle(3); preamble_sfd();
      for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, pl[i], (i == 2) ? 1'b1 : 1'b0);
      idle(8);
      check("rstdrop_n", 32'(obs_q.size()), 32'd0);

      // next frame after reset received normally
      seg_begin();
      idle(2); preamble_sfd();
      drive(1'b1, 1'b0, 8'h5A, 1'b0);
      drive(1'b1, 1'b0, 8'hD5, 1'b0);
      drive(1'b1, 1'b0, 8'h55, 1'b0);
      drive(1'b1, 1'b0, 8'hE7, 1'b0);
      seg_compare("afterrst");

      // random traffic
      for (int s = 0; s < 4; s++) begin
         seg_begin();
         idle(2);
         repeat (12) rand_frame();
         seg_compare("random");
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
